// File: rtl/vctr_load_ctrl.sv
// Frame sequencer: parses SYNC/select/length/payload/checksum frames from the UART
// byte stream, writes payloads into the chosen vector store and strobes commit or error.
module vctr_load_ctrl #(
  parameter int         MAX_LEN   = 16,
  parameter int         ADDR_W    = 4,
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         TIMEOUT   = 50000
) (
  input  logic              clock,
  input  logic              nrst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              in_ready,
  input  logic              out_ready,
  output logic              wr_en,
  output logic              wr_sel,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              vctr_comp_in,
  output logic              vctr_comp_out,
  output logic              frame_err,
  output logic [1:0]        err_code,
  output logic              busy
);

  localparam int              TO_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  localparam logic [1:0] ERR_TO   = 2'b00;
  localparam logic [1:0] ERR_SEL  = 2'b01;
  localparam logic [1:0] ERR_LEN  = 2'b10;
  localparam logic [1:0] ERR_CSUM = 2'b11;

  typedef enum logic [2:0] {IDLE, SEL, LEN, DATA, CSUM} state_t;

  state_t            state_q, state_d;
  logic              sel_q, sel_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [7:0]        csum_q, csum_d;
  logic [TO_W-1:0]   tmr_q, tmr_d;
  logic              wr_en_q, wr_en_d;
  logic              wr_sel_q, wr_sel_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              comp_in_q, comp_in_d;
  logic              comp_out_q, comp_out_d;
  logic              frame_err_q, frame_err_d;
  logic [1:0]        err_code_q, err_code_d;
  logic              busy_q, busy_d;
  logic              abort;
  logic [1:0]        abort_code;

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    last_d      = last_q;
    idx_d       = idx_q;
    csum_d      = csum_q;
    wr_en_d     = 1'b0;
    wr_sel_d    = wr_sel_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    comp_in_d   = 1'b0;
    comp_out_d  = 1'b0;
    frame_err_d = 1'b0;
    err_code_d  = err_code_q;
    abort       = 1'b0;
    abort_code  = ERR_TO;
    tmr_d       = (rx_valid || state_q == IDLE) ? '0 : tmr_q + TO_W'(1);

    if (rx_valid) begin
      case (state_q)
        IDLE: if (rx_data == SYNC_BYTE) state_d = SEL;
        SEL: begin
          if (rx_data == 8'h00 && in_ready) begin
            sel_d   = 1'b0;
            state_d = LEN;
          end else if (rx_data == 8'h01 && out_ready) begin
            sel_d   = 1'b1;
            state_d = LEN;
          end else begin
            abort      = 1'b1;
            abort_code = ERR_SEL;
          end
        end
        LEN: begin
          if (rx_data != 8'h00 && rx_data <= 8'(MAX_LEN)) begin
            // store len-1 so the last payload byte is a plain index compare
            last_d  = ADDR_W'(rx_data - 8'd1);
            idx_d   = '0;
            csum_d  = '0;
            state_d = DATA;
          end else begin
            abort      = 1'b1;
            abort_code = ERR_LEN;
          end
        end
        DATA: begin
          wr_en_d   = 1'b1;
          wr_sel_d  = sel_q;
          wr_addr_d = idx_q;
          wr_data_d = rx_data;
          csum_d    = csum_q ^ rx_data;
          idx_d     = idx_q + ADDR_W'(1);
          if (idx_q == last_q) state_d = CSUM;
        end
        CSUM: begin
          if (rx_data == csum_q) begin
            state_d    = IDLE;
            comp_in_d  = ~sel_q;
            comp_out_d = sel_q;
          end else begin
            abort      = 1'b1;
            abort_code = ERR_CSUM;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && tmr_q == TO_LAST) begin
      abort      = 1'b1;
      abort_code = ERR_TO;
    end

    if (abort) begin
      state_d     = IDLE;
      frame_err_d = 1'b1;
      err_code_d  = abort_code;
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or posedge nrst) begin
    if (nrst) begin
      state_q     <= IDLE;
      sel_q       <= 1'b0;
      last_q      <= '0;
      idx_q       <= '0;
      csum_q      <= '0;
      tmr_q       <= '0;
      wr_en_q     <= 1'b0;
      wr_sel_q    <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      comp_in_q   <= 1'b0;
      comp_out_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= 2'b00;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      last_q      <= last_d;
      idx_q       <= idx_d;
      csum_q      <= csum_d;
      tmr_q       <= tmr_d;
      wr_en_q     <= wr_en_d;
      wr_sel_q    <= wr_sel_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      comp_in_q   <= comp_in_d;
      comp_out_q  <= comp_out_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
      busy_q      <= busy_d;
    end
  end

  assign wr_en         = wr_en_q;
  assign wr_sel        = wr_sel_q;
  assign wr_addr       = wr_addr_q;
  assign wr_data       = wr_data_q;
  assign vctr_comp_in  = comp_in_q;
  assign vctr_comp_out = comp_out_q;
  assign frame_err     = frame_err_q;
  assign err_code      = err_code_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_vctr_load_ctrl.sv
// Bench for vctr_load_ctrl: directed and random frame streams compared cycle by cycle
// against a frame-level model of the expected store writes, commits and errors.
module tb_vctr_load_ctrl;
  localparam int TMO  = 20;
  localparam int MAXL = 16;
  localparam int AW   = 4;
  localparam int MAXC = 8000;

  logic          clock = 1'b0;
  logic          nrst  = 1'b1;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data  = 8'h00;
  logic          in_ready = 1'b0;
  logic          out_ready = 1'b0;
  logic          wr_en, wr_sel, vctr_comp_in, vctr_comp_out, frame_err, busy;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic [1:0]    err_code;
  logic [19:0]   all_o;

  always #5 clock = ~clock;

  vctr_load_ctrl #(.MAX_LEN(MAXL), .ADDR_W(AW), .SYNC_BYTE(8'hA5), .TIMEOUT(TMO)) dut (
    .clock(clock), .nrst(nrst), .rx_valid(rx_valid), .rx_data(rx_data),
    .in_ready(in_ready), .out_ready(out_ready), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_addr(wr_addr), .wr_data(wr_data), .vctr_comp_in(vctr_comp_in),
    .vctr_comp_out(vctr_comp_out), .frame_err(frame_err), .err_code(err_code), .busy(busy)
  );

  assign all_o = {wr_en, wr_sel, wr_addr, wr_data, vctr_comp_in, vctr_comp_out,
                  frame_err, err_code, busy};

  int n_chk = 0, n_fail = 0, cyc = 0, n_cyc = 0;

  logic          q_v[MAXC], q_ir[MAXC], q_or[MAXC];
  logic [7:0]    q_d[MAXC];
  logic          e_we[MAXC], e_sel[MAXC], e_ci[MAXC], e_co[MAXC], e_fe[MAXC], e_busy[MAXC];
  logic [AW-1:0] e_addr[MAXC];
  logic [7:0]    e_dat[MAXC];
  logic [1:0]    e_cd[MAXC];
  logic          bset[MAXC], bclr[MAXC];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic push(input logic v, input logic [7:0] d, input logic ir, input logic orr);
    if (n_cyc < MAXC) begin
      q_v[n_cyc] = v; q_d[n_cyc] = d; q_ir[n_cyc] = ir; q_or[n_cyc] = orr;
      n_cyc++;
    end
  endtask

  task automatic add_idle(input int n);
    for (int i = 0; i < n; i++) push(1'b0, 8'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic add_byte(input logic [7:0] b);
    push(1'b1, b, 1'($urandom), 1'($urandom));
  endtask

  // the addressed store's ready is forced; the other one is random
  task automatic add_sel(input logic [7:0] b, input logic rdy);
    push(1'b1, b, (b == 8'h00) ? rdy : 1'($urandom), (b == 8'h01) ? rdy : 1'($urandom));
  endtask

  task automatic add_gap();
    add_idle(($urandom_range(0, 15) == 0) ? TMO - 1 : $urandom_range(0, 2));
  endtask

  // kind: 0-4 good, 5 bad select, 6 target not ready, 7 bad length, 8 bad csum, 9 truncated
  task automatic add_frame(input int kind);
    logic       s;
    int         len, cut;
    logic [7:0] sum, b;
    s   = 1'($urandom);
    len = $urandom_range(1, MAXL);
    cut = $urandom_range(0, len - 1);
    add_byte(8'hA5); add_gap();
    if (kind == 5) begin
      add_sel(8'($urandom_range(2, 255)), 1'b1);
      return;
    end
    add_sel({7'd0, s}, kind != 6);
    if (kind == 6) return;
    add_gap();
    if (kind == 7) begin
      b = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(MAXL + 1, 255));
      add_byte(b);
      return;
    end
    add_byte(8'(len));
    sum = 8'h00;
    for (int i = 0; i < len; i++) begin
      if (kind == 9 && i == cut) begin
        add_idle(TMO + $urandom_range(0, 4));
        return;
      end
      add_gap();
      b = 8'($urandom);
      sum ^= b;
      add_byte(b);
    end
    add_gap();
    add_byte((kind == 8) ? (sum ^ 8'($urandom_range(1, 255))) : sum);
  endtask

  task automatic mark_err(input int c, input logic [1:0] code);
    e_fe[c] = 1'b1; e_cd[c] = code; bclr[c] = 1'b1;
  endtask

  // Frame-position parser over the timed byte list; entries indexed by the sampling cycle
  task automatic run_model();
    int pos = 0, last = 0, len = 0, cnt = 0;
    logic msel = 1'b0;
    logic [7:0] sum = 8'h00, b;
    logic hs = 1'b0, hb = 1'b0;
    logic [AW-1:0] ha = '0;
    logic [7:0] hd = 8'h00;
    logic [1:0] hc = 2'b00;
    for (int c = 0; c < n_cyc; c++) begin
      e_we[c] = 0; e_ci[c] = 0; e_co[c] = 0; e_fe[c] = 0; bset[c] = 0; bclr[c] = 0;
      e_sel[c] = 0; e_addr[c] = '0; e_dat[c] = 0; e_cd[c] = 0;
      if (pos != 0 && !q_v[c] && (c - last) == TMO) begin
        mark_err(c, 2'd0); pos = 0;
      end else if (q_v[c]) begin
        b = q_d[c]; last = c;
        case (pos)
          0: if (b == 8'hA5) begin pos = 1; bset[c] = 1'b1; end
          1: begin
            if (b == 8'h00 && q_ir[c]) begin msel = 1'b0; pos = 2; end
            else if (b == 8'h01 && q_or[c]) begin msel = 1'b1; pos = 2; end
            else begin mark_err(c, 2'd1); pos = 0; end
          end
          2: begin
            if (b >= 1 && b <= MAXL) begin len = b; cnt = 0; sum = 8'h00; pos = 3; end
            else begin mark_err(c, 2'd2); pos = 0; end
          end
          3: begin
            e_we[c] = 1'b1; e_sel[c] = msel; e_addr[c] = AW'(cnt); e_dat[c] = b;
            sum ^= b; cnt++;
            if (cnt == len) pos = 4;
          end
          default: begin
            if (b == sum) begin
              if (msel) e_co[c] = 1'b1; else e_ci[c] = 1'b1;
              bclr[c] = 1'b1;
            end else mark_err(c, 2'd3);
            pos = 0;
          end
        endcase
      end
    end
    for (int c = 0; c < n_cyc; c++) begin
      if (e_we[c]) begin hs = e_sel[c]; ha = e_addr[c]; hd = e_dat[c]; end
      else begin e_sel[c] = hs; e_addr[c] = ha; e_dat[c] = hd; end
      if (e_fe[c]) hc = e_cd[c]; else e_cd[c] = hc;
      if (bset[c]) hb = 1'b1;
      if (bclr[c]) hb = 1'b0;
      e_busy[c] = hb;
    end
  endtask

  task automatic run_segment();
    for (int c = 0; c < n_cyc; c++) begin
      rx_valid = q_v[c]; rx_data = q_d[c]; in_ready = q_ir[c]; out_ready = q_or[c];
      @(posedge clock); #1;
      cyc = c;
      chk("wr", 32'({wr_en, wr_sel, wr_addr, wr_data}),
          32'({e_we[c], e_sel[c], e_addr[c], e_dat[c]}));
      chk("evt", 32'({vctr_comp_in, vctr_comp_out, frame_err, err_code}),
          32'({e_ci[c], e_co[c], e_fe[c], e_cd[c]}));
      chk("busy", 32'(busy), 32'(e_busy[c]));
    end
    rx_valid = 1'b0;
  endtask

  task automatic drive_byte(input logic [7:0] b);
    rx_valid = 1'b1; rx_data = b; in_ready = 1'b1;
    @(posedge clock); #1;
    rx_valid = 1'b0;
  endtask

  task automatic add_random(input int n);
    logic [7:0] nb;
    for (int f = 0; f < n; f++) begin
      if ($urandom_range(0, 3) == 0) begin
        nb = 8'($urandom);
        add_byte((nb == 8'hA5) ? 8'h5A : nb);
      end
      add_frame($urandom_range(0, 9));
      add_idle($urandom_range(0, 3));
    end
    add_idle(TMO + 5);
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    cyc = -1;
    chk("reset_outs", 32'(all_o), 32'd0);
    nrst = 1'b0;

    n_cyc = 0;
    add_byte(8'h3C);
    add_byte(8'hA5); add_sel(8'h00, 1'b1); add_byte(8'h03);
    add_byte(8'h11); add_byte(8'h22); add_byte(8'h33); add_byte(8'h00);
    add_byte(8'hA5); add_sel(8'h01, 1'b1); add_byte(8'h10);
    for (int i = 0; i < 16; i++) add_byte(8'(i));
    add_byte(8'h00);
    add_idle(2);
    add_byte(8'hA5); add_sel(8'h02, 1'b1); add_idle(1);
    add_byte(8'hA5); add_sel(8'h00, 1'b0); add_idle(1);
    add_byte(8'hA5); add_sel(8'h00, 1'b1); add_byte(8'h00); add_idle(1);
    add_byte(8'hA5); add_sel(8'h00, 1'b1); add_byte(8'h11); add_idle(1);
    add_byte(8'hA5); add_sel(8'h00, 1'b1); add_byte(8'h02);
    add_byte(8'h0F); add_byte(8'hF0); add_byte(8'h00); add_idle(1);
    add_byte(8'hA5); add_sel(8'h00, 1'b1); add_byte(8'h02); add_byte(8'h55);
    add_idle(TMO + 4);
    add_byte(8'hA5); add_sel(8'h00, 1'b1); add_byte(8'h02); add_byte(8'h55);
    add_idle(TMO - 1);
    add_byte(8'hAA); add_byte(8'hFF); add_idle(3);
    add_random(60);
    run_model();
    run_segment();

    drive_byte(8'hA5); drive_byte(8'h00); drive_byte(8'h04); drive_byte(8'h01);
    cyc = -2;
    chk("pre_rst_wr_en", 32'(wr_en), 32'd1);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #2 nrst = 1'b1;
    #1;
    chk("mid_rst_outs", 32'(all_o), 32'd0);
    @(posedge clock); #1;
    nrst = 1'b0;

    n_cyc = 0;
    add_byte(8'hA5); add_sel(8'h00, 1'b1); add_byte(8'h03);
    add_byte(8'h11); add_byte(8'h22); add_byte(8'h33); add_byte(8'h00);
    add_idle(2);
    add_random(25);
    run_model();
    run_segment();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
